qspi_host_ctrl: RTL and testbench
=================================

# qspi_host_ctrl

Synthesizable QSPI host controller that initiates command/address/dummy/data transactions toward a serial flash-style device on the QSPI pins. It sits between an SoC register block or bus bridge, which supplies a transaction descriptor and a start pulse, and the pad-level lanes. It serves as the initiator for the team's QSPI device model and flash targets. It generates the serial clock, per-lane chip selects and output enables, shifts out command/address/write data MSB-first, and collects read data.

## Interface
- CLK_DIV, 2: spi_clk half-period in clk cycles; legal range ≥1.
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  transaction request; sampled only while busy=0.
- rw  in  1  1=read data phase, 0=write data phase.
- quad  in  1  1=4 lanes for every phase, 0=lane 0 only.
- cmd  in  32  command, right-justified.
- cmd_len  in  6  command bits, 0..32.
- addr  in  32  address, right-justified.
- addr_len  in  6  address bits, 0..32.
- dummy_cycles  in  8  dummy spi_clk periods, 0..255.
- wdata  in  32  write data, right-justified.
- data_len  in  6  data bits, 0..32.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle pulse at transaction end.
- cfg_err  out  1  one-cycle pulse when start is rejected.
- rdata  out  32  read data, right-justified; held until next accepted start.
- spi_clk  out  1  serial clock; idles low.
- spi_csn0..spi_csn3  out  1 each  active-low lane selects.
- spi_sdo0..spi_sdo3  out  1 each  host-driven lane data.
- spi_oe0..spi_oe3  out  1 each  host drive enable per lane.
- spi_sdi0..spi_sdi3  in  1 each  device-driven lane data.

## Operation
- Reset values: busy=0, done=0, cfg_err=0, rdata=0, spi_clk=0, all csn=1, all sdo=0, all oe=0. The state is IDLE.
- Lane width is w=4 when quad=1, else w=1.
- Active lanes:
  - quad=1: all four csn are low during a transaction.
  - quad=0: only csn0 is low; csn1..3 stay at 1.
- Start rejection: start with busy=0 is rejected if any of the following holds:
  - any length >32;
  - cmd_len, addr_len or data_len is not a multiple of w;
  - cmd_len=addr_len=data_len=0.
  On rejection, cfg_err pulses for one cycle and no pins change.
- Accepted start: all inputs are latched, rdata is cleared, and the block enters the first non-empty phase. Later changes to the inputs are ignored until done.
- State machine: IDLE → CMD → ADDR → DUMMY → DATA → IDLE.
  - Any phase whose length is 0 is skipped.
  - After the last phase the block returns to IDLE.
- Shift order is MSB first. Each spi_clk period carries w bits.
  - Quad: sdo3 carries the most significant bit of the current nibble and sdo0 the least.
  - Single: sdo0 carries the bit.
- CMD, ADDR, and DATA with rw=0: oe is 1 on the active lanes and 0 on inactive lanes.
- DUMMY: oe=0 and sdo=0 on all lanes; one spi_clk period per count.
- DATA with rw=1: oe=0 and sdo=0 on all lanes. Each period, rdata = (rdata<<w) | {sdi3,sdi2,sdi1,sdi0} in quad, or (rdata<<1) | sdi0 in single. The result ends right-justified at data_len bits.
- Counters:
  - Divider counter, 0..CLK_DIV-1.
  - Per-phase bit counter, 0..32 in steps of w.
  - Dummy counter, 8 bits.
  - No wrap-around is possible within legal lengths.

## Timing
- Let T0 be the edge at which start is accepted. Let N = (cmd_len + addr_len + data_len)/w + dummy_cycles.
- At T0+1: busy=1, active csn=0, and the first bits are valid on sdo with spi_clk=0.
- Rising edges of spi_clk occur at T0+1+CLK_DIV+2k·CLK_DIV; falling edges occur CLK_DIV later, for k=0..N-1.
- The device samples host data on the rising edge. The host changes sdo only on the falling edge.
- Read data is sampled by the host on each falling edge of the DATA phase, i.e. CLK_DIV cycles after the rising edge on which the device drives.
- At T0+1+2N·CLK_DIV, all of the following happen together:
  - all csn=1, all oe=0, sdo=0;
  - done=1 for one cycle;
  - busy=0;
  - rdata is final.
- Back-to-back: a start present in the done cycle is accepted. csn is then high for exactly one clk cycle before the next transaction.
- A start while busy=1 is ignored; it produces no error pulse.
- rst asserted mid-transaction: every output returns to its reset value at the next clk edge, and no done is produced.

## Test plan
- WRITE_ENABLE, single, CLK_DIV=2: cmd=0x6, cmd_len=16, other lengths 0 → 16 spi_clk pulses, sdo0 carries 0x0006 MSB-first, csn0 low for 64 cycles, csn1..3 high, oe0=1, done at T0+65.
- Quad page program: cmd=0x2/16, addr=0x0010/16, wdata=0xDEADBEEF/32, rw=0, dummy=0 → 16 spi_clk periods; the device model stores data[0x10]=0xDEADBEEF.
- Quad read: cmd=0x3/16, addr=0x0010/16, dummy=2, data_len=32, rw=1 → rdata=0xDEADBEEF at done, all oe=0 during dummy and data, N=18.
- Config error: quad=1, cmd_len=6 → cfg_err pulse, busy stays 0, csn stays 0xF, no spi_clk edges.
- Back-to-back: start held high through the done cycle → second transaction begins at the next edge, with csn high for exactly one cycle between transactions.
- Reset during ADDR phase → next edge shows csn=0xF, spi_clk=0, oe=0, busy=0, no done; a following WRITE_ENABLE completes normally.

Source files
------------

// File: rtl/qspi_host_ctrl_if.sv
// Descriptor/handshake bundle between an SoC requester and the QSPI host controller.
// The master side supplies the descriptor and start pulse; the slave side is the controller.
interface qspi_host_ctrl_if;
  logic        start;
  logic        rw;
  logic        quad;
  logic [31:0] cmd;
  logic [5:0]  cmd_len;
  logic [31:0] addr;
  logic [5:0]  addr_len;
  logic [7:0]  dummy_cycles;
  logic [31:0] wdata;
  logic [5:0]  data_len;
  logic        busy;
  logic        done;
  logic        cfg_err;
  logic [31:0] rdata;

  modport master (
    output start, rw, quad, cmd, cmd_len, addr, addr_len, dummy_cycles, wdata, data_len,
    input  busy, done, cfg_err, rdata
  );

  modport slave (
    input  start, rw, quad, cmd, cmd_len, addr, addr_len, dummy_cycles, wdata, data_len,
    output busy, done, cfg_err, rdata
  );
endinterface

// File: rtl/qspi_host_ctrl.sv
// QSPI host: runs CMD/ADDR/DUMMY/DATA phases MSB-first on 1 or 4 lanes.
// spi_clk is generated from clk; sdo changes on falling edges, read data is sampled there too.
module qspi_host_ctrl #(
  parameter int CLK_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  qspi_host_ctrl_if.slave  bus,
  output logic             spi_clk,
  output logic             spi_csn0,
  output logic             spi_csn1,
  output logic             spi_csn2,
  output logic             spi_csn3,
  output logic             spi_sdo0,
  output logic             spi_sdo1,
  output logic             spi_sdo2,
  output logic             spi_sdo3,
  output logic             spi_oe0,
  output logic             spi_oe1,
  output logic             spi_oe2,
  output logic             spi_oe3,
  input  logic             spi_sdi0,
  input  logic             spi_sdi1,
  input  logic             spi_sdi2,
  input  logic             spi_sdi3
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA} state_t;

  state_t           state_r;
  logic [DIV_W-1:0] div_cnt_r;
  logic [5:0]       bit_cnt_r;
  logic [7:0]       dummy_cnt_r;
  logic [31:0]      sh_r;
  logic             rw_r, quad_r;
  logic [31:0]      cmd_r, addr_r, wdata_r;
  logic [5:0]       cmd_len_r, addr_len_r, data_len_r;
  logic [7:0]       dummy_r;
  logic             busy_r, done_r, cfg_err_r, spi_clk_r;
  logic [31:0]      rdata_r;
  logic [3:0]       csn_r, sdo_r, oe_r;

  logic             idle_s, cfg_ok_s, phase_end_s;
  logic             src_rw_s, src_quad_s;
  logic [31:0]      src_cmd_s, src_addr_s, src_wdata_s;
  logic [5:0]       src_cmd_len_s, src_addr_len_s, src_data_len_s, step_s;
  logic [7:0]       src_dummy_s;
  state_t           nxt_phase_s;
  logic [31:0]      nxt_word_s, sh_shift_s;

  // First non-empty phase strictly after cur, IDLE when none remain.
  function automatic state_t phase_after(input state_t cur, input logic [5:0] cl,
                                         input logic [5:0] al, input logic [7:0] dm,
                                         input logic [5:0] dl);
    state_t nxt;
    if ((cur == IDLE) && (cl != 6'd0))
      nxt = CMD;
    else if ((cur inside {IDLE, CMD}) && (al != 6'd0))
      nxt = ADDR;
    else if ((cur inside {IDLE, CMD, ADDR}) && (dm != 8'd0))
      nxt = DUMMY;
    else if ((cur != DATA) && (dl != 6'd0))
      nxt = DATA;
    else
      nxt = IDLE;
    return nxt;
  endfunction

  // Left-aligns the right-justified field so the MSB sits at bit 31.
  function automatic logic [31:0] phase_word(input state_t ph, input logic rw,
                                             input logic [31:0] c, input logic [5:0] cl,
                                             input logic [31:0] a, input logic [5:0] al,
                                             input logic [31:0] d, input logic [5:0] dl);
    logic [31:0] w;
    case (ph)
      CMD:     w = c << (6'd32 - cl);
      ADDR:    w = a << (6'd32 - al);
      DATA:    w = rw ? 32'd0 : (d << (6'd32 - dl));
      default: w = 32'd0;
    endcase
    return w;
  endfunction

  function automatic logic [3:0] lanes(input logic [31:0] w, input logic q);
    return q ? w[31:28] : {3'b000, w[31]};
  endfunction

  function automatic logic [3:0] phase_oe(input state_t ph, input logic rw, input logic q);
    logic [3:0] m;
    case (ph)
      CMD, ADDR: m = q ? 4'hF : 4'h1;
      DATA:      m = rw ? 4'h0 : (q ? 4'hF : 4'h1);
      default:   m = 4'h0;
    endcase
    return m;
  endfunction

  // Descriptor source (live inputs when idle), start validation and phase sequencing.
  always_comb begin
    idle_s         = (state_r == IDLE);
    src_rw_s       = idle_s ? bus.rw           : rw_r;
    src_quad_s     = idle_s ? bus.quad         : quad_r;
    src_cmd_s      = idle_s ? bus.cmd          : cmd_r;
    src_cmd_len_s  = idle_s ? bus.cmd_len      : cmd_len_r;
    src_addr_s     = idle_s ? bus.addr         : addr_r;
    src_addr_len_s = idle_s ? bus.addr_len     : addr_len_r;
    src_dummy_s    = idle_s ? bus.dummy_cycles : dummy_r;
    src_wdata_s    = idle_s ? bus.wdata        : wdata_r;
    src_data_len_s = idle_s ? bus.data_len     : data_len_r;

    cfg_ok_s = (bus.cmd_len <= 6'd32) && (bus.addr_len <= 6'd32) && (bus.data_len <= 6'd32)
            && !(bus.quad && ((bus.cmd_len[1:0] | bus.addr_len[1:0] | bus.data_len[1:0]) != 2'b00))
            && !((bus.cmd_len == 6'd0) && (bus.addr_len == 6'd0) && (bus.data_len == 6'd0));

    nxt_phase_s = phase_after(state_r, src_cmd_len_s, src_addr_len_s, src_dummy_s, src_data_len_s);
    nxt_word_s  = phase_word(nxt_phase_s, src_rw_s, src_cmd_s, src_cmd_len_s,
                             src_addr_s, src_addr_len_s, src_wdata_s, src_data_len_s);

    step_s     = quad_r ? 6'd4 : 6'd1;
    sh_shift_s = quad_r ? {sh_r[27:0], 4'h0} : {sh_r[30:0], 1'b0};
    case (state_r)
      CMD:     phase_end_s = ((bit_cnt_r + step_s) == cmd_len_r);
      ADDR:    phase_end_s = ((bit_cnt_r + step_s) == addr_len_r);
      DATA:    phase_end_s = ((bit_cnt_r + step_s) == data_len_r);
      DUMMY:   phase_end_s = (dummy_cnt_r == (dummy_r - 8'd1));
      default: phase_end_s = 1'b0;
    endcase
  end

  // Transaction FSM, spi_clk divider and all registered pin/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      div_cnt_r   <= {DIV_W{1'b0}};
      bit_cnt_r   <= 6'd0;
      dummy_cnt_r <= 8'd0;
      sh_r        <= 32'd0;
      rw_r        <= 1'b0;
      quad_r      <= 1'b0;
      cmd_r       <= 32'd0;
      addr_r      <= 32'd0;
      wdata_r     <= 32'd0;
      cmd_len_r   <= 6'd0;
      addr_len_r  <= 6'd0;
      data_len_r  <= 6'd0;
      dummy_r     <= 8'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      cfg_err_r   <= 1'b0;
      spi_clk_r   <= 1'b0;
      rdata_r     <= 32'd0;
      csn_r       <= 4'hF;
      sdo_r       <= 4'h0;
      oe_r        <= 4'h0;
    end else begin
      done_r    <= 1'b0;
      cfg_err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start && cfg_ok_s) begin
            rw_r        <= bus.rw;
            quad_r      <= bus.quad;
            cmd_r       <= bus.cmd;
            addr_r      <= bus.addr;
            wdata_r     <= bus.wdata;
            cmd_len_r   <= bus.cmd_len;
            addr_len_r  <= bus.addr_len;
            data_len_r  <= bus.data_len;
            dummy_r     <= bus.dummy_cycles;
            rdata_r     <= 32'd0;
            busy_r      <= 1'b1;
            state_r     <= nxt_phase_s;
            sh_r        <= nxt_word_s;
            sdo_r       <= lanes(nxt_word_s, bus.quad);
            oe_r        <= phase_oe(nxt_phase_s, bus.rw, bus.quad);
            csn_r       <= bus.quad ? 4'h0 : 4'hE;
            div_cnt_r   <= {DIV_W{1'b0}};
            bit_cnt_r   <= 6'd0;
            dummy_cnt_r <= 8'd0;
            spi_clk_r   <= 1'b0;
          end else begin
            cfg_err_r <= bus.start;
          end
        end
        CMD, ADDR, DUMMY, DATA: begin
          if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= {DIV_W{1'b0}};
            if (!spi_clk_r) begin
              spi_clk_r <= 1'b1;
            end else begin
              // Falling edge: capture read data, then advance the bit stream.
              spi_clk_r <= 1'b0;
              if ((state_r == DATA) && rw_r)
                rdata_r <= quad_r ? {rdata_r[27:0], spi_sdi3, spi_sdi2, spi_sdi1, spi_sdi0}
                                  : {rdata_r[30:0], spi_sdi0};
              else
                rdata_r <= rdata_r;
              if (phase_end_s) begin
                bit_cnt_r   <= 6'd0;
                dummy_cnt_r <= 8'd0;
                state_r     <= nxt_phase_s;
                sh_r        <= nxt_word_s;
                sdo_r       <= lanes(nxt_word_s, quad_r);
                oe_r        <= phase_oe(nxt_phase_s, rw_r, quad_r);
                if (nxt_phase_s == IDLE) begin
                  busy_r <= 1'b0;
                  done_r <= 1'b1;
                  csn_r  <= 4'hF;
                end else begin
                  csn_r  <= csn_r;
                end
              end else begin
                bit_cnt_r   <= bit_cnt_r + step_s;
                dummy_cnt_r <= dummy_cnt_r + 8'd1;
                sh_r        <= sh_shift_s;
                sdo_r       <= lanes(sh_shift_s, quad_r);
              end
            end
          end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.cfg_err = cfg_err_r;
  assign bus.rdata   = rdata_r;
  assign spi_clk     = spi_clk_r;
  assign {spi_csn3, spi_csn2, spi_csn1, spi_csn0} = csn_r;
  assign {spi_sdo3, spi_sdo2, spi_sdo1, spi_sdo0} = sdo_r;
  assign {spi_oe3,  spi_oe2,  spi_oe1,  spi_oe0}  = oe_r;

endmodule

// File: tb/tb_qspi_host_ctrl.sv
// Directed bench for qspi_host_ctrl (CLK_DIV=2) with a small QSPI device model
// that records host bit streams and returns stored data on quad reads.
module tb_qspi_host_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  qspi_host_ctrl_if bus();

  logic spi_clk;
  logic spi_csn0, spi_csn1, spi_csn2, spi_csn3;
  logic spi_sdo0, spi_sdo1, spi_sdo2, spi_sdo3;
  logic spi_oe0, spi_oe1, spi_oe2, spi_oe3;
  logic [3:0] sdi = 4'h0;

  qspi_host_ctrl #(.CLK_DIV(2)) dut (
    .clk(clk), .rst(rst), .bus(bus), .spi_clk(spi_clk),
    .spi_csn0(spi_csn0), .spi_csn1(spi_csn1), .spi_csn2(spi_csn2), .spi_csn3(spi_csn3),
    .spi_sdo0(spi_sdo0), .spi_sdo1(spi_sdo1), .spi_sdo2(spi_sdo2), .spi_sdo3(spi_sdo3),
    .spi_oe0(spi_oe0), .spi_oe1(spi_oe1), .spi_oe2(spi_oe2), .spi_oe3(spi_oe3),
    .spi_sdi0(sdi[0]), .spi_sdi1(sdi[1]), .spi_sdi2(sdi[2]), .spi_sdi3(sdi[3])
  );

  wire [3:0] csn = {spi_csn3, spi_csn2, spi_csn1, spi_csn0};
  wire [3:0] oe  = {spi_oe3, spi_oe2, spi_oe1, spi_oe0};
  wire [3:0] sdo = {spi_sdo3, spi_sdo2, spi_sdo1, spi_sdo0};

  int checks = 0;
  int errors = 0;

  // Device model: samples host lanes on rising spi_clk, drives the stored word during
  // periods 10..17 (cmd 4 + addr 4 + dummy 2 periods precede quad read data).
  logic [63:0] cap_q = 64'd0;
  logic [15:0] cap_s = 16'd0;
  logic [31:0] mem_word = 32'd0;
  int pcnt = 0;
  always @(posedge spi_clk or posedge spi_csn0) begin
    if (spi_csn0) begin
      pcnt <= 0;
    end else begin
      cap_q <= {cap_q[59:0], spi_sdo3, spi_sdo2, spi_sdo1, spi_sdo0};
      cap_s <= {cap_s[14:0], spi_sdo0};
      if (pcnt >= 10 && pcnt < 18) sdi <= mem_word[4*(17-pcnt) +: 4];
      else sdi <= 4'h0;
      pcnt <= pcnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_desc(input logic rw_i, input logic quad_i,
                          input logic [31:0] c, input logic [5:0] cl,
                          input logic [31:0] a, input logic [5:0] al,
                          input logic [7:0] dm, input logic [31:0] wd, input logic [5:0] dl);
    bus.rw = rw_i; bus.quad = quad_i; bus.cmd = c; bus.cmd_len = cl;
    bus.addr = a; bus.addr_len = al; bus.dummy_cycles = dm; bus.wdata = wd; bus.data_len = dl;
  endtask

  // Called at the negedge right after the accepting edge (k=0); returns at the negedge
  // where done is visible, so lat = 2*N*CLK_DIV.
  task automatic wait_done(input int oe_from, output int lat, output int rises,
                           output int lowc, output logic [3:0] oe_or,
                           output logic [3:0] csn_and, output logic cerr);
    logic prev;
    prev = 1'b0; lat = 0; rises = 0; lowc = 0; oe_or = 4'h0; csn_and = 4'hF; cerr = 1'b0;
    while (1) begin
      if (spi_clk && !prev) rises++;
      if (!spi_csn0) lowc++;
      if (lat >= oe_from) oe_or |= oe;
      csn_and &= csn;
      cerr |= bus.cfg_err;
      if (bus.done || lat >= 1000) break;
      prev = spi_clk;
      @(negedge clk);
      lat++;
    end
    chk("done_seen", bus.done, 1'b1);
  endtask

  task automatic pulse_start;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  int lat, rises, lowc, n;
  logic [3:0] oe_or, csn_and;
  logic cerr, seen;

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    set_desc(1'b0, 1'b0, 32'd0, 6'd0, 32'd0, 6'd0, 8'd0, 32'd0, 6'd0);
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_cfg_err", bus.cfg_err, 1'b0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_spi_clk", spi_clk, 1'b0);
    chk("rst_csn", csn, 4'hF);
    chk("rst_sdo", sdo, 4'h0);
    chk("rst_oe", oe, 4'h0);
    rst = 1'b0;
    @(negedge clk);

    // WRITE_ENABLE, single lane: N=16
    set_desc(1'b0, 1'b0, 32'h6, 6'd16, 32'd0, 6'd0, 8'd0, 32'd0, 6'd0);
    pulse_start();
    chk("we_busy_t1", bus.busy, 1'b1);
    chk("we_csn_t1", csn, 4'hE);
    chk("we_oe_t1", oe, 4'h1);
    chk("we_spi_clk_t1", spi_clk, 1'b0);
    wait_done(0, lat, rises, lowc, oe_or, csn_and, cerr);
    chk("we_latency", lat, 64);
    chk("we_rises", rises, 16);
    chk("we_csn0_low", lowc, 64);
    chk("we_csn_and", csn_and, 4'hE);
    chk("we_oe_or", oe_or, 4'h1);
    chk("we_stream", cap_s, 16'h0006);
    chk("we_end_busy", bus.busy, 1'b0);
    chk("we_end_csn", csn, 4'hF);
    chk("we_end_oe", oe, 4'h0);
    chk("we_end_sdo", sdo, 4'h0);
    @(negedge clk);
    chk("we_done_pulse", bus.done, 1'b0);

    // Quad page program: N=(16+16+32)/4=16
    set_desc(1'b0, 1'b1, 32'h2, 6'd16, 32'h10, 6'd16, 8'd0, 32'hDEADBEEF, 6'd32);
    pulse_start();
    chk("pp_sdo_t1", sdo, 4'h0);
    wait_done(0, lat, rises, lowc, oe_or, csn_and, cerr);
    chk("pp_latency", lat, 64);
    chk("pp_rises", rises, 16);
    chk("pp_csn_and", csn_and, 4'h0);
    chk("pp_oe_or", oe_or, 4'hF);
    chk("pp_stream", cap_q, 64'h0002_0010_DEADBEEF);
    if (cap_q[63:48] == 16'h0002 && cap_q[47:32] == 16'h0010) mem_word = cap_q[31:0];
    else mem_word = 32'd0;
    @(negedge clk);

    // Quad read: N=4+4+2+8=18; oe must stay 0 from dummy onward (k>=32)
    set_desc(1'b1, 1'b1, 32'h3, 6'd16, 32'h10, 6'd16, 8'd2, 32'd0, 6'd32);
    pulse_start();
    wait_done(32, lat, rises, lowc, oe_or, csn_and, cerr);
    chk("rd_latency", lat, 72);
    chk("rd_rises", rises, 18);
    chk("rd_oe_dummy_data", oe_or, 4'h0);
    chk("rd_rdata", bus.rdata, 32'hDEADBEEF);
    @(negedge clk);

    // Rejected starts: misaligned quad, >32, all-empty (dummy alone is not enough)
    set_desc(1'b0, 1'b1, 32'h3F, 6'd6, 32'd0, 6'd0, 8'd0, 32'd0, 6'd0);
    pulse_start();
    chk("cfg_align_err", bus.cfg_err, 1'b1);
    chk("cfg_align_busy", bus.busy, 1'b0);
    chk("cfg_align_csn", csn, 4'hF);
    chk("cfg_rdata_held", bus.rdata, 32'hDEADBEEF);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen |= spi_clk | bus.busy | bus.cfg_err;
    end
    chk("cfg_align_quiet", seen, 1'b0);
    set_desc(1'b0, 1'b0, 32'h6, 6'd33, 32'd0, 6'd0, 8'd0, 32'd0, 6'd0);
    pulse_start();
    chk("cfg_len33_err", bus.cfg_err, 1'b1);
    @(negedge clk);
    set_desc(1'b0, 1'b0, 32'h0, 6'd0, 32'd0, 6'd0, 8'd3, 32'd0, 6'd0);
    pulse_start();
    chk("cfg_empty_err", bus.cfg_err, 1'b1);
    chk("cfg_empty_csn", csn, 4'hF);
    @(negedge clk);

    // Back-to-back WRITE_ENABLE with start held through the first done cycle
    set_desc(1'b0, 1'b0, 32'h6, 6'd16, 32'd0, 6'd0, 8'd0, 32'd0, 6'd0);
    bus.start = 1'b1;
    @(negedge clk);
    chk("b2b_rdata_cleared", bus.rdata, 32'd0);
    wait_done(0, lat, rises, lowc, oe_or, csn_and, cerr);
    chk("b2b_first_latency", lat, 64);
    chk("b2b_busy_start_no_err", cerr, 1'b0);
    chk("b2b_gap_csn", spi_csn0, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_second_csn", spi_csn0, 1'b0);
    chk("b2b_second_busy", bus.busy, 1'b1);
    chk("b2b_second_done", bus.done, 1'b0);
    wait_done(0, lat, rises, lowc, oe_or, csn_and, cerr);
    chk("b2b_second_latency", lat, 64);
    @(negedge clk);

    // Reset in the middle of ADDR (cmd occupies k=0..15, addr k=16..31)
    set_desc(1'b0, 1'b1, 32'h2, 6'd16, 32'h10, 6'd16, 8'd0, 32'hDEADBEEF, 6'd32);
    pulse_start();
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_csn", csn, 4'hF);
    chk("mrst_spi_clk", spi_clk, 1'b0);
    chk("mrst_oe", oe, 4'h0);
    chk("mrst_sdo", sdo, 4'h0);
    chk("mrst_busy", bus.busy, 1'b0);
    rst = 1'b0;
    seen = 1'b0;
    n = 0;
    while (n < 60) begin
      seen |= bus.done | spi_clk;
      @(negedge clk);
      n++;
    end
    chk("mrst_no_done", seen, 1'b0);
    set_desc(1'b0, 1'b0, 32'h6, 6'd16, 32'd0, 6'd0, 8'd0, 32'd0, 6'd0);
    pulse_start();
    wait_done(0, lat, rises, lowc, oe_or, csn_and, cerr);
    chk("mrst_we_latency", lat, 64);
    chk("mrst_we_stream", cap_s, 16'h0006);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
